// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter with inhibit, request-to-send, odd parity and ack check
module ps2_host_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk_chipset,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam longint INH_L  = longint'(INHIBIT_US) * longint'(CLK_HZ) / 1_000_000;
  localparam longint TO_L   = longint'(TIMEOUT_US) * longint'(CLK_HZ) / 1_000_000;
  localparam int     INH_CYC = int'(INH_L);
  localparam int     TO_CYC  = int'(TO_L);
  localparam int     TMAX    = TO_CYC > INH_CYC ? TO_CYC : INH_CYC;
  localparam int     TW      = $clog2(TMAX + 1);
  localparam int     FW      = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, RELEASE, DONE, ERR} state_t;

  state_t        st_q;
  logic [1:0]    clk_s_q, dat_s_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic [9:0]    sh_q;
  logic [3:0]    cnt_q;
  logic [TW-1:0] tmr_q;
  logic          clk_oe_q, dat_oe_q, done_q, err_q;
  logic          flip, fall, dat_s;

  assign flip       = (clk_s_q[1] != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
  assign fall       = flip && filt_q;
  assign dat_s      = dat_s_q[1];
  assign tx_ready   = st_q == IDLE;
  assign busy       = st_q != IDLE;
  assign tx_done    = done_q;
  assign tx_error   = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

  // Synchronise both pins and debounce CLK: a level change is accepted only after FILTER_LEN agreeing samples
  always_ff @(posedge clk_chipset or posedge reset)
    if (reset) begin
      clk_s_q <= 2'b11;
      dat_s_q <= 2'b11;
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
    end else begin
      clk_s_q <= {clk_s_q[0], ps2_clk_i};
      dat_s_q <= {dat_s_q[0], ps2_dat_i};
      if (clk_s_q[1] == filt_q) fcnt_q <= '0;
      else if (flip) begin
        filt_q <= clk_s_q[1];
        fcnt_q <= '0;
      end else fcnt_q <= fcnt_q + 1'b1;
    end

  // Transfer FSM: pin drives and pulses are registered; DATA only changes in the cycle after a filtered fall
  always_ff @(posedge clk_chipset or posedge reset)
    if (reset) begin
      st_q     <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (st_q)
        IDLE:
          if (tx_valid) begin
            sh_q     <= {1'b1, ~^tx_data, tx_data};
            tmr_q    <= TW'(INH_CYC - 1);
            clk_oe_q <= 1'b1;
            st_q     <= INHIBIT;
          end
        INHIBIT:
          if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
          else if (!dat_oe_q) dat_oe_q <= 1'b1;
          else begin
            clk_oe_q <= 1'b0;
            tmr_q    <= TW'(TO_CYC);
            st_q     <= RTS;
          end
        RTS, SHIFT, ACK, RELEASE: begin
          tmr_q <= fall ? TW'(TO_CYC) : tmr_q - 1'b1;
          if (!fall && tmr_q == '0) begin
            st_q     <= ERR;
            err_q    <= 1'b1;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
          end else if (st_q == RTS && fall) begin
            dat_oe_q <= ~sh_q[0];
            cnt_q    <= 4'd1;
            st_q     <= SHIFT;
          end else if (st_q == SHIFT && fall) begin
            sh_q     <= sh_q >> 1;
            dat_oe_q <= ~sh_q[1];
            cnt_q    <= cnt_q + 4'd1;
            if (cnt_q == 4'd9) st_q <= ACK;
          end else if (st_q == ACK && fall) begin
            st_q     <= dat_s ? ERR : RELEASE;
            err_q    <= dat_s;
            dat_oe_q <= 1'b0;
          end else if (st_q == RELEASE && filt_q && dat_s) begin
            st_q   <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE:    st_q <= IDLE;
        ERR:     st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table, random and corner-case checks of ps2_host_tx against a PS/2 device model
module tb_ps2_host_tx;
  localparam int H   = 20;
  localparam int INH = 100;
  localparam int TO  = 2000;

  logic       clk = 0, reset = 1, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic       dev_clk_low = 0, dev_dat_low = 0;
  logic       tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_i, ps2_dat_i;
  int checks = 0, failures = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, inh_meas = 0;

  assign ps2_clk_i = !(ps2_clk_oe || dev_clk_low);
  assign ps2_dat_i = !(ps2_dat_oe || dev_dat_low);

  ps2_host_tx #(.CLK_HZ(1_000_000), .INHIBIT_US(100), .TIMEOUT_US(2000), .FILTER_LEN(8)) dut (
    .clk_chipset(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
    .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i), .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  // Pulse bookkeeping and measurement of the CLK-only inhibit phase
  always @(negedge clk) begin
    if (!reset) begin
      done_cnt += int'(tx_done);
      err_cnt  += int'(tx_error);
      both_cnt += int'(tx_done && tx_error);
    end
    if (ps2_clk_oe && !ps2_dat_oe) inh_cnt++;
    else begin
      if (ps2_dat_oe && inh_cnt != 0) inh_meas = inh_cnt;
      inh_cnt = 0;
    end
  end

  typedef struct {
    logic [7:0]  d;
    bit          ack;
    logic [10:0] fr;
    int          dn;
    int          er;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] model(input logic [7:0] d);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic wait_rts(output bit ok);
    int n = 0;
    while (!(ps2_clk_i && !ps2_dat_i) && n < 2 * INH + 50) begin
      cyc(1);
      n++;
    end
    ok = n < 2 * INH + 50;
  endtask

  task automatic fall_sample(output logic b);
    dev_clk_low = 1;
    cyc(H);
    dev_clk_low = 0;
    cyc(H / 2);
    b = ps2_dat_i;
    cyc(H / 2);
  endtask

  task automatic xfer(input bit ack, input bit junk, output logic [10:0] fr);
    bit ok;
    logic b;
    fr = 'x;
    wait_rts(ok);
    chk("rts_seen", 32'(ok), 1);
    if (!ok) return;
    cyc(H);
    fr[0] = ps2_dat_i;
    for (int k = 1; k <= 10; k++) begin
      if (junk && k == 5) begin
        tx_data  = ~tx_data;
        tx_valid = 1;
        cyc(1);
        tx_valid = 0;
      end
      fall_sample(b);
      fr[k] = b;
    end
    dev_dat_low = ack;
    cyc(4);
    dev_clk_low = 1;
    cyc(H);
    dev_clk_low = 0;
    cyc(H);
    dev_dat_low = 0;
    cyc(20);
  endtask

  initial begin
    logic [10:0] fr;
    logic [7:0]  d;
    logic        b;
    bit          ok;
    int          d0, e0, c;
    tbl[0] = '{8'hED, 1'b1, 11'b1_1_11101101_0, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 11'b1_1_00000000_0, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 11'b1_1_11111111_0, 1, 0};
    tbl[3] = '{8'h01, 1'b1, 11'b1_0_00000001_0, 1, 0};
    tbl[4] = '{8'hED, 1'b0, 11'b1_1_11101101_0, 0, 1};
    cyc(3);
    chk("reset_outputs", {tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 6'b100000);
    reset = 0;
    cyc(3);
    chk("post_reset_idle", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);

    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(tbl[i].d);
      xfer(tbl[i].ack, 1'b0, fr);
      chk($sformatf("tbl%0d_frame", i), 32'(fr), 32'(tbl[i].fr));
      chk($sformatf("tbl%0d_inhibit_cycles", i), inh_meas, INH);
      chk($sformatf("tbl%0d_done_pulses", i), done_cnt - d0, tbl[i].dn);
      chk($sformatf("tbl%0d_error_pulses", i), err_cnt - e0, tbl[i].er);
      chk($sformatf("tbl%0d_idle_after", i), {tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
    end

    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      d0 = done_cnt;
      e0 = err_cnt;
      send(d);
      xfer(1'b1, i == 2, fr);
      chk($sformatf("rnd%0d_frame_%02h", i, d), 32'(fr), 32'(model(d)));
      chk($sformatf("rnd%0d_done_pulses", i), done_cnt - d0, 1);
      chk($sformatf("rnd%0d_error_pulses", i), err_cnt - e0, 0);
    end

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hA5);
    c = 0;
    while (ps2_clk_oe && c < 2 * INH + 50) begin
      cyc(1);
      c++;
    end
    c = 0;
    while (!tx_error && c < TO + 100) begin
      cyc(1);
      c++;
    end
    chk("timeout_error_seen", 32'(tx_error), 1);
    chk("timeout_window", 32'(c >= TO && c <= TO + 2), 1);
    cyc(1);
    chk("timeout_idle_after", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
    cyc(2);
    chk("timeout_error_pulses", err_cnt - e0, 1);
    chk("timeout_done_pulses", done_cnt - d0, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    fr = '0;
    send(8'h55);
    wait_rts(ok);
    chk("glitch_rts_seen", 32'(ok), 1);
    cyc(H);
    fr[0] = ps2_dat_i;
    for (int k = 1; k <= 3; k++) begin
      fall_sample(b);
      fr[k] = b;
    end
    dev_clk_low = 1;
    cyc(3);
    dev_clk_low = 0;
    cyc(H);
    fall_sample(b);
    fr[4] = b;
    chk("glitch_no_advance", 32'(fr[4:0]), 5'b01010);
    chk("pre_reset_dat_oe", 32'(ps2_dat_oe), 1);
    #2 reset = 1;
    #1 chk("async_reset_release", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
    cyc(3);
    reset = 0;
    cyc(5);
    chk("reset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    d0 = done_cnt;
    send(8'hFF);
    xfer(1'b1, 1'b0, fr);
    chk("after_reset_frame", 32'(fr), 32'(model(8'hFF)));
    chk("after_reset_done", done_cnt - d0, 1);
    chk("done_error_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
